// File: rtl/bwp_pkg.sv
// Shared types and helpers for the binary window pooling stage.
// The macro BWP_MAJORITY_EN adds a fourth, majority-vote plane.
package bwp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } bwp_state_e;

    // Plane order inside pool_out
    localparam int PL_OR  = 0;
    localparam int PL_PAR = 1;
    localparam int PL_AND = 2;
    localparam int PL_MAJ = 3;

`ifdef BWP_MAJORITY_EN
    localparam int BWP_PLANES = 4;
`else
    localparam int BWP_PLANES = 3;
`endif

    // Window positions per axis. Bad inputs return 1 so elaboration reaches
    // the parameter check instead of dividing by zero.
    function automatic int out_dim(input int row_limit, input int win, input int stride);
        if (stride < 1 || win < 1 || win > row_limit)
            return 1;
        return (row_limit - win) / stride + 1;
    endfunction

    // Bits needed to index 0..v-1, never less than one.
    function automatic int clog2Min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/bwp_window_reduce.sv
// Combinational reduction of one WIN x WIN binary window into OR, parity and
// AND bits; with BWP_MAJORITY_EN also a majority bit from a popcount.
module bwp_window_reduce #(
    parameter int WIN = 3
) (
    input  logic [WIN*WIN-1:0] winBits,
    output logic               orBit,
    output logic               parBit,
    output logic               andBit
`ifdef BWP_MAJORITY_EN
    ,
    output logic               majBit
`endif
);

    localparam int N = WIN * WIN;

    // Parity flips to XNOR for even windows so an all-zero even window reads 1
    always_comb begin
        orBit  = |winBits;
        andBit = &winBits;
        parBit = (WIN % 2 == 1) ? ^winBits : ~^winBits;
    end

`ifdef BWP_MAJORITY_EN
    localparam int CNT_W = $clog2(N + 1);
    logic [CNT_W-1:0] ones;

    // Strict majority: more than half of the window pixels set
    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++)
            ones = ones + CNT_W'(winBits[i]);
        majBit = (ones > CNT_W'(N / 2));
    end
`endif

endmodule

// File: rtl/binary_window_pool.sv
// Sequential binary window pooling: latch an image on start, visit one window
// per clock, write OR/parity/AND (plus majority with BWP_MAJORITY_EN) into a
// packed multi-plane map, then pulse done.
module binary_window_pool
    import bwp_pkg::*;
#(
    parameter  int ROW_LIMIT = 10,
    parameter  int WIN       = 3,
    parameter  int STRIDE    = 1,
    localparam int OUT_DIM   = out_dim(ROW_LIMIT, WIN, STRIDE),
    localparam int NWIN      = OUT_DIM * OUT_DIM,
    localparam int PLANES    = BWP_PLANES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ROW_LIMIT*ROW_LIMIT-1:0] in_data,
    output logic                           busy,
    output logic                           done,
    output logic [PLANES*NWIN-1:0]         pool_out
);

    localparam int PIX = ROW_LIMIT * ROW_LIMIT;
    localparam int CW  = clog2Min1(OUT_DIM);
    localparam int IW  = clog2Min1(PIX);
    localparam int NIW = clog2Min1(NWIN);
    localparam int PIW = clog2Min1(PLANES * NWIN);

    generate
        if (WIN < 1 || WIN > ROW_LIMIT || STRIDE < 1 ||
            ((ROW_LIMIT - WIN) % ((STRIDE < 1) ? 1 : STRIDE)) != 0) begin : gBadParams
            $error("binary_window_pool: illegal ROW_LIMIT/WIN/STRIDE combination");
        end
    endgenerate

    bwp_state_e          state, stateNxt;
    logic [PIX-1:0]      image;
    logic [CW-1:0]       oy, ox;
    logic                lastCol, lastWin;
    logic [IW-1:0]       rowBase, colBase, pixIdx;
    logic [WIN*WIN-1:0]  winBits;
    logic [NIW-1:0]      winIdx;
    logic [PLANES-1:0]   red;
    logic [PLANES-1:0][PIW-1:0] wrIdx;
    logic                orBit, parBit, andBit;
`ifdef BWP_MAJORITY_EN
    logic                majBit;
`endif

    assign lastCol = (ox == CW'(OUT_DIM - 1));
    assign lastWin = lastCol && (oy == CW'(OUT_DIM - 1));
    assign rowBase = IW'(oy) * IW'(STRIDE);
    assign colBase = IW'(ox) * IW'(STRIDE);
    assign winIdx  = NIW'(oy) * NIW'(OUT_DIM) + NIW'(ox);

    // Gather the current window out of the latched image, row-major
    always_comb begin
        winBits = '0;
        pixIdx  = '0;
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
                pixIdx = (rowBase + IW'(i)) * IW'(ROW_LIMIT) + colBase + IW'(j);
                winBits[i*WIN+j] = image[pixIdx];
            end
        end
    end

    bwp_window_reduce #(.WIN(WIN)) uReduce (
        .winBits (winBits),
        .orBit   (orBit),
        .parBit  (parBit),
        .andBit  (andBit)
`ifdef BWP_MAJORITY_EN
        ,
        .majBit  (majBit)
`endif
    );

    // Pack reduction bits by plane and compute each plane's write position
    always_comb begin
        red         = '0;
        red[PL_OR]  = orBit;
        red[PL_PAR] = parBit;
        red[PL_AND] = andBit;
`ifdef BWP_MAJORITY_EN
        red[PL_MAJ] = majBit;
`endif
        wrIdx = '0;
        for (int p = 0; p < PLANES; p++)
            wrIdx[p] = PIW'(p * NWIN) + PIW'(winIdx);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNxt;
    end

    // Next state and status outputs
    always_comb begin
        stateNxt = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE:    if (start) stateNxt = SCAN;
            SCAN:    if (lastWin) stateNxt = DONE;
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Image capture, window counters and result map
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            image    <= '0;
            pool_out <= '0;
            oy       <= '0;
            ox       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    image    <= in_data;
                    pool_out <= '0;
                    oy       <= '0;
                    ox       <= '0;
                end
                SCAN: begin
                    for (int p = 0; p < PLANES; p++)
                        pool_out[wrIdx[p]] <= red[p];
                    if (lastCol) begin
                        ox <= '0;
                        oy <= lastWin ? '0 : oy + 1'b1;
                    end else begin
                        ox <= ox + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_window_pool.sv
// Self-checking bench for binary_window_pool: a default-size instance (10/3/1)
// and a small one (4/2/2). Works with or without BWP_MAJORITY_EN.
`timescale 1ns/1ps
module tb_binary_window_pool;

    localparam int RL = 10, W = 3, S = 1, OD = 8, NW = 64;
`ifdef BWP_MAJORITY_EN
    localparam int PL = 4;
`else
    localparam int PL = 3;
`endif
    localparam int PWA = PL * NW;
    localparam int NWB = 4;
    localparam int PWB = PL * NWB;

    logic clk = 1'b0, rst_n = 1'b0, startA = 1'b0, startB = 1'b0;
    logic [RL*RL-1:0] inA = '0;
    logic [15:0] inB = '0;
    logic busyA, doneA, busyB, doneB;
    logic [PWA-1:0] poolA;
    logic [PWB-1:0] poolB;

    int nVec = 0, nMis = 0;
    logic [PWA-1:0] expQ[$];

    typedef struct {
        logic [RL*RL-1:0] img;
        logic [PWA-1:0]   exp;
        string            nm;
    } vecA_t;
    typedef struct {
        logic [15:0]    img;
        logic [PWB-1:0] exp;
        string          nm;
    } vecB_t;
    vecA_t va[6];
    vecB_t vb[3];

    always #5 clk = ~clk;

    binary_window_pool #(.ROW_LIMIT(RL), .WIN(W), .STRIDE(S)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .in_data(inA),
        .busy(busyA), .done(doneA), .pool_out(poolA)
    );

    binary_window_pool #(.ROW_LIMIT(4), .WIN(2), .STRIDE(2)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .in_data(inB),
        .busy(busyB), .done(doneB), .pool_out(poolB)
    );

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: count ones per window, derive each plane from the count
    function automatic logic [PWA-1:0] modelA(input logic [RL*RL-1:0] img);
        logic [PWA-1:0] r;
        int c, k;
        r = '0;
        for (int oy = 0; oy < OD; oy++) begin
            for (int ox = 0; ox < OD; ox++) begin
                c = 0;
                for (int i = 0; i < W; i++)
                    for (int j = 0; j < W; j++)
                        c += int'(img[(oy*S+i)*RL + ox*S + j]);
                k = oy * OD + ox;
                r[k]        = (c > 0);
                r[NW + k]   = (W % 2 == 1) ? (c % 2 == 1) : (c % 2 == 0);
                r[2*NW + k] = (c == W * W);
`ifdef BWP_MAJORITY_EN
                r[3*NW + k] = (c > (W * W) / 2);
`endif
            end
        end
        return r;
    endfunction

    function automatic logic [RL*RL-1:0] rndImg(input int mode);
        logic [127:0] a, b;
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (mode == 0) return a[RL*RL-1:0];
        if (mode == 1) return (a & b) >> 28;
        return (a | b) >> 28;
    endfunction

    // One scan on instance A: push expectation, start, wait for done, compare
    task automatic runA(input logic [RL*RL-1:0] img, input logic [PWA-1:0] exp, input string nm);
        int n;
        bit busyOk;
        @(negedge clk);
        inA = img;
        startA = 1'b1;
        expQ.push_back(exp);
        @(posedge clk);
        #1 startA = 1'b0;
        n = 0;
        busyOk = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            if (doneA) break;
            if (!busyA) busyOk = 1'b0;
            @(posedge clk);
            n++;
        end
        if (!doneA) begin
            chk({nm, " timeout"}, 256'(n), 256'(NW));
            expQ.delete();
        end else begin
            chk({nm, " latency"}, 256'(n), 256'(NW));
            chk({nm, " busy held"}, 256'(busyOk), 256'(1));
            chk({nm, " pool_out"}, 256'(poolA), 256'(expQ.pop_front()));
            @(posedge clk);
            @(negedge clk);
            chk({nm, " idle after"}, 256'({busyA, doneA}), 256'(0));
        end
    endtask

    task automatic runB(input logic [15:0] img, input logic [PWB-1:0] exp, input string nm);
        int n;
        @(negedge clk);
        inB = img;
        startB = 1'b1;
        @(posedge clk);
        #1 startB = 1'b0;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (doneB) break;
            @(posedge clk);
            n++;
        end
        chk({nm, " latency"}, 256'(n), 256'(NWB));
        chk({nm, " pool_out"}, 256'(poolB), 256'(exp));
        @(posedge clk);
        @(negedge clk);
        chk({nm, " idle after"}, 256'({busyB, doneB}), 256'(0));
    endtask

    initial begin
        logic [RL*RL-1:0] img1, img2;
        logic [PWA-1:0] e;
        logic [PWB-1:0] eb;
        int n, d1, d2, dones, dAt;

        // Vector tables
        va[0] = '{'0, '0, "A zeros"};
        va[1] = '{'1, '1, "A ones"};
        e = '0; e[0] = 1'b1; e[NW] = 1'b1;
        va[2] = '{100'd1, e, "A pixel00"};
        for (int i = 3; i < 6; i++) begin
            img1 = rndImg(i - 3);
            va[i] = '{img1, modelA(img1), $sformatf("A rand%0d", i)};
        end
        eb = '0; eb[7:4] = 4'hF;
        vb[0] = '{16'h0000, eb, "B zeros"};
        vb[1] = '{16'hFFFF, '1, "B ones"};
        eb = '0; eb[0] = 1'b1; eb[7:5] = 3'b111;
        vb[2] = '{16'h0001, eb, "B pixel00"};

        // Reset state, before any clock edge
        #1;
        chk("reset A status", 256'({busyA, doneA}), 256'(0));
        chk("reset A pool", 256'(poolA), 256'(0));
        chk("reset B status", 256'({busyB, doneB}), 256'(0));
        chk("reset B pool", 256'(poolB), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) runA(va[i].img, va[i].exp, va[i].nm);
        for (int i = 0; i < 3; i++) runB(vb[i].img, vb[i].exp, vb[i].nm);

        // Result holds in IDLE while in_data wanders
        runA('1, '1, "A ones again");
        @(negedge clk);
        inA = rndImg(0);
        repeat (5) @(negedge clk);
        chk("A hold in idle", 256'(poolA), {(256-PWA)'(0), {PWA{1'b1}}});

        // Asynchronous reset in the middle of a scan
        @(negedge clk);
        inA = '1;
        startA = 1'b1;
        @(posedge clk);
        #1 startA = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midscan reset status", 256'({busyA, doneA}), 256'(0));
        chk("midscan reset pool", 256'(poolA), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        runA('1, '1, "A after reset");

        // Restart attempt plus in_data change during scan are both ignored
        @(negedge clk);
        inA = '0;
        startA = 1'b1;
        @(posedge clk);
        #1 startA = 1'b0;
        repeat (10) @(posedge clk);
        #1 startA = 1'b1;
        inA = '1;
        repeat (3) @(posedge clk);
        #1 startA = 1'b0;
        dones = 0;
        dAt = -1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (doneA) begin
                dones++;
                dAt = c;
                chk("ignored restart pool", 256'(poolA), 256'(0));
            end
        end
        chk("ignored restart done count", 256'(dones), 256'(1));
        chk("ignored restart latency", 256'(dAt), 256'(NW - 13));

        // start held high: back-to-back scans, NWIN+2 apart
        img1 = rndImg(0);
        img2 = rndImg(2);
        @(negedge clk);
        inA = img1;
        startA = 1'b1;
        expQ.push_back(modelA(img1));
        expQ.push_back(modelA(img2));
        @(posedge clk);
        #1 inA = img2;
        n = 0;
        d1 = -1;
        d2 = -1;
        while (n < 300 && d2 < 0) begin
            @(negedge clk);
            if (doneA) begin
                if (expQ.size() == 0) chk("held start extra done", 256'(1), 256'(0));
                else chk("held start pool", 256'(poolA), 256'(expQ.pop_front()));
                if (d1 < 0) d1 = n;
                else d2 = n;
            end
            @(posedge clk);
            n++;
        end
        #1 startA = 1'b0;
        chk("held start first done", 256'(d1), 256'(NW));
        chk("held start second done", 256'(d2), 256'(2 * NW + 2));
        repeat (3) @(negedge clk);
        chk("held start back to idle", 256'(busyA), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
